// File: rtl/lcg_stim_gen_if.sv
// rtl/lcg_stim_gen_if.sv - valid/ready stimulus vector stream between generator and consumer
interface lcg_stim_gen_if #(
    parameter int WIDTH = 137
);
    logic             vec_valid;
    logic             vec_ready;
    logic [WIDTH-1:0] vec_data;

    modport master (
        output vec_valid,
        output vec_data,
        input  vec_ready
    );

    modport slave (
        input  vec_valid,
        input  vec_data,
        output vec_ready
    );
endinterface

// File: rtl/lcg_stim_gen.sv
// rtl/lcg_stim_gen.sv - LCG stimulus vector generator with valid/ready output
module lcg_stim_gen #(
    parameter int          WIDTH = 137,
    parameter logic [31:0] MULT  = 32'h41C64E6D,
    parameter logic [31:0] INC   = 32'h3039,
    parameter logic [31:0] SEED  = 32'd4120381792
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seed_load,
    input  logic [31:0]          seed_in,
    input  logic                 start,
    input  logic [31:0]          num_vectors,
    lcg_stim_gen_if.master       vec,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          vec_count
);
    localparam int NWORDS = (WIDTH + 31) / 32;
    localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PAD_W  = NWORDS * 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PRESENT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       lcg_state;
    logic [31:0]       lcg_next;
    logic [31:0]       target;
    logic [IDX_W-1:0]  word_idx;
    logic [WIDTH-1:0]  data_q;
    logic [WIDTH-1:0]  slot_data;
    logic [WIDTH-1:0]  slot_mask;
    logic              load_seed;
    logic              begin_run;
    logic              fill_step;
    logic              accept;

    assign lcg_next = lcg_state * MULT + INC;

    // Place the next LCG word into its slot; bits past WIDTH fall off the cast,
    // which is how the last word gets truncated while still consuming a step.
    always_comb begin
        slot_data = WIDTH'(PAD_W'(lcg_next) << {word_idx, 5'b0});
        slot_mask = WIDTH'(PAD_W'(32'hFFFF_FFFF) << {word_idx, 5'b0});
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_next = state;
        load_seed  = 1'b0;
        begin_run  = 1'b0;
        fill_step  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (seed_load) begin
                    load_seed = 1'b1;
                end else if (start) begin
                    if (num_vectors != 32'd0) begin
                        begin_run  = 1'b1;
                        state_next = FILL;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            FILL: begin
                fill_step = 1'b1;
                if (word_idx == LAST_IDX) begin
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (vec.vec_ready) begin
                    accept     = 1'b1;
                    state_next = (vec_count + 32'd1 == target) ? DONE : FILL;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // LCG state, vector assembly, run length and accepted-vector count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcg_state <= SEED;
            data_q    <= '0;
            word_idx  <= '0;
            target    <= 32'd0;
            vec_count <= 32'd0;
        end else begin
            if (load_seed) begin
                lcg_state <= seed_in;
            end
            if (begin_run) begin
                target    <= num_vectors;
                vec_count <= 32'd0;
                word_idx  <= '0;
            end
            if (fill_step) begin
                lcg_state <= lcg_next;
                data_q    <= (data_q & ~slot_mask) | slot_data;
                word_idx  <= (word_idx == LAST_IDX) ? '0 : word_idx + IDX_W'(1);
            end
            if (accept) begin
                vec_count <= vec_count + 32'd1;
            end
        end
    end

    assign vec.vec_valid = (state == PRESENT);
    assign vec.vec_data  = data_q;
    assign busy          = (state == FILL) || (state == PRESENT);
    assign done          = (state == DONE);
endmodule

// File: tb/tb_lcg_stim_gen.sv
// tb/tb_lcg_stim_gen.sv - self-checking bench for lcg_stim_gen against a software LCG model
module tb_lcg_stim_gen;
    localparam int          W    = 137;
    localparam int          NW   = 5;
    localparam logic [31:0] MULT = 32'h41C64E6D;
    localparam logic [31:0] INC  = 32'h3039;
    localparam logic [31:0] SEED = 32'd4120381792;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [31:0] seed_in = 32'd0;
    logic        start = 1'b0;
    logic [31:0] num_vectors = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] vec_count;

    lcg_stim_gen_if #(.WIDTH(W)) vif ();

    lcg_stim_gen #(.WIDTH(W), .MULT(MULT), .INC(INC), .SEED(SEED)) dut (
        .clk         (clk),
        .rst         (rst),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .start       (start),
        .num_vectors (num_vectors),
        .vec         (vif),
        .busy        (busy),
        .done        (done),
        .vec_count   (vec_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_total = 0;
    int busy_total = 0;

    always @(posedge clk) begin
        if (done) done_total <= done_total + 1;
        if (busy) busy_total <= busy_total + 1;
    end

    logic [31:0]  model_s;
    logic [W-1:0] first_vec;

    function automatic logic [W-1:0] gen_vec();
        logic [NW*32-1:0] full;
        full = '0;
        for (int k = 0; k < NW; k++) begin
            model_s = model_s * MULT + INC;
            full[k*32 +: 32] = model_s;
        end
        return full[W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] n);
        start = 1'b1;
        num_vectors = n;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (vif.vec_valid) ok = 1'b1;
            else step();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (done) ok = 1'b1;
            else step();
        end
        if (ok) step();
    endtask

    task automatic collect_vec(input int stall, output logic [W-1:0] d, output bit ok, output bit stable);
        wait_valid(ok);
        stable = 1'b1;
        d = '0;
        if (ok) begin
            d = vif.vec_data;
            repeat (stall) begin
                step();
                if (!vif.vec_valid || vif.vec_data !== d) stable = 1'b0;
            end
            vif.vec_ready = 1'b1;
            step();
            vif.vec_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (vif.vec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", vif.vec_valid); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_busy_done got=%0b%0b want=00", busy, done); end
        total++; if (vec_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", vec_count); end
        total++; if (vif.vec_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", vif.vec_data); end
        rst = 1'b0;
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%0b want=0", busy); end
        model_s = SEED;
    endtask

    task automatic test_seed_zero();
        int n;
        int d0;
        logic [W-1:0] exp;
        seed_load = 1'b1;
        seed_in = 32'd0;
        step();
        seed_load = 1'b0;
        model_s = 32'd0;
        exp = gen_vec();
        vif.vec_ready = 1'b1;
        d0 = done_total;
        start_run(32'd1);
        n = 1;
        while (!vif.vec_valid && n < 20) begin
            step();
            n++;
        end
        total++; if (n !== 6) begin bad++; $display("FAIL seed0_latency got=%0d want=6", n); end
        total++; if (vif.vec_data[31:0] !== 32'h00003039) begin bad++; $display("FAIL seed0_word0 got=%h want=00003039", vif.vec_data[31:0]); end
        total++; if (vif.vec_data[63:32] !== 32'hD3DC167E) begin bad++; $display("FAIL seed0_word1 got=%h want=d3dc167e", vif.vec_data[63:32]); end
        total++; if (vif.vec_data !== exp) begin bad++; $display("FAIL seed0_vec got=%h want=%h", vif.vec_data, exp); end
        step();
        vif.vec_ready = 1'b0;
        step();
        step();
        step();
        total++; if (done_total - d0 !== 1) begin bad++; $display("FAIL seed0_done_pulses got=%0d want=1", done_total - d0); end
        total++; if (vec_count !== 32'd1) begin bad++; $display("FAIL seed0_count got=%0d want=1", vec_count); end
    endtask

    task automatic test_stall();
        logic [W-1:0] got [3];
        logic [W-1:0] exp;
        bit ok;
        bit stable;
        int d0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        model_s = SEED;
        d0 = done_total;
        start_run(32'd3);
        for (int v = 0; v < 3; v++) begin
            exp = gen_vec();
            if (v == 0) first_vec = exp;
            collect_vec(4, got[v], ok, stable);
            total++; if (!ok) begin bad++; $display("FAIL stall_valid_timeout vec=%0d got=timeout want=valid", v); end
            total++; if (!stable) begin bad++; $display("FAIL stall_stable vec=%0d got=changed want=held", v); end
            total++; if (got[v] !== exp) begin bad++; $display("FAIL stall_vec%0d got=%h want=%h", v, got[v], exp); end
        end
        total++; if (got[0] === got[1] || got[1] === got[2]) begin bad++; $display("FAIL stall_distinct got=equal want=distinct"); end
        wait_done(ok);
        total++; if (!ok) begin bad++; $display("FAIL stall_done_timeout got=timeout want=done"); end
        total++; if (vec_count !== 32'd3) begin bad++; $display("FAIL stall_count got=%0d want=3", vec_count); end
        total++; if (done_total - d0 !== 1) begin bad++; $display("FAIL stall_done_pulses got=%0d want=1", done_total - d0); end
    endtask

    task automatic test_zero_count();
        logic [W-1:0] got;
        logic [W-1:0] exp;
        bit ok;
        bit stable;
        int b0;
        b0 = busy_total;
        start = 1'b1;
        num_vectors = 32'd0;
        step();
        start = 1'b0;
        total++; if (done !== 1'b1 || vif.vec_valid !== 1'b0) begin bad++; $display("FAIL zero_done got=done%0b valid%0b want=done1 valid0", done, vif.vec_valid); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_done_width got=%0b want=0", done); end
        total++; if (busy_total !== b0) begin bad++; $display("FAIL zero_busy got=%0d want=%0d", busy_total, b0); end
        exp = gen_vec();
        start_run(32'd1);
        collect_vec(0, got, ok, stable);
        total++; if (got !== exp) begin bad++; $display("FAIL zero_lcg_kept got=%h want=%h", got, exp); end
        wait_done(ok);
    endtask

    task automatic test_reset_mid_fill();
        logic [W-1:0] got;
        bit ok;
        bit stable;
        start_run(32'd2);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0 || vif.vec_valid !== 1'b0) begin bad++; $display("FAIL midreset_flags got=busy%0b done%0b valid%0b want=000", busy, done, vif.vec_valid); end
        total++; if (vif.vec_data !== '0 || vec_count !== 32'd0) begin bad++; $display("FAIL midreset_data got=%h cnt=%0d want=0", vif.vec_data, vec_count); end
        step();
        rst = 1'b0;
        step();
        model_s = SEED;
        first_vec = gen_vec();
        start_run(32'd1);
        collect_vec($urandom_range(0, 3), got, ok, stable);
        total++; if (got !== first_vec) begin bad++; $display("FAIL midreset_restart got=%h want=%h", got, first_vec); end
        wait_done(ok);
    endtask

    task automatic test_ignored();
        logic [W-1:0] got;
        logic [W-1:0] exp;
        logic [31:0] seed_val;
        bit ok;
        bit stable;
        int d0;
        start_run(32'd2);
        exp = gen_vec();
        wait_valid(ok);
        start = 1'b1;
        num_vectors = 32'd7;
        seed_load = 1'b1;
        seed_in = $urandom;
        step();
        start = 1'b0;
        seed_load = 1'b0;
        total++; if (vif.vec_data !== exp) begin bad++; $display("FAIL ign_vec0 got=%h want=%h", vif.vec_data, exp); end
        vif.vec_ready = 1'b1;
        step();
        vif.vec_ready = 1'b0;
        exp = gen_vec();
        collect_vec(1, got, ok, stable);
        total++; if (got !== exp) begin bad++; $display("FAIL ign_vec1 got=%h want=%h", got, exp); end
        wait_done(ok);
        total++; if (!ok || vec_count !== 32'd2) begin bad++; $display("FAIL ign_count got=%0d want=2", vec_count); end
        seed_val = $urandom;
        d0 = done_total;
        seed_load = 1'b1;
        seed_in = seed_val;
        start = 1'b1;
        num_vectors = 32'd1;
        step();
        seed_load = 1'b0;
        start = 1'b0;
        step();
        step();
        total++; if (busy !== 1'b0 || done_total !== d0) begin bad++; $display("FAIL ign_same_cycle got=busy%0b dones%0d want=busy0 dones%0d", busy, done_total, d0); end
        model_s = seed_val;
        exp = gen_vec();
        start_run(32'd1);
        collect_vec(0, got, ok, stable);
        total++; if (got !== exp) begin bad++; $display("FAIL ign_seed_loaded got=%h want=%h", got, exp); end
        wait_done(ok);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ref_vec [4];
        logic [W-1:0] got;
        logic [31:0] seed_val;
        bit ok;
        bit stable;
        seed_val = $urandom;
        seed_load = 1'b1;
        seed_in = seed_val;
        step();
        seed_load = 1'b0;
        model_s = seed_val;
        for (int i = 0; i < 4; i++) ref_vec[i] = gen_vec();
        for (int r = 0; r < 2; r++) begin
            start_run(32'd2);
            for (int v = 0; v < 2; v++) begin
                collect_vec($urandom_range(0, 3), got, ok, stable);
                total++; if (got !== ref_vec[2*r+v]) begin bad++; $display("FAIL b2b_run%0d_vec%0d got=%h want=%h", r, v, got, ref_vec[2*r+v]); end
            end
            wait_done(ok);
            total++; if (!ok || vec_count !== 32'd2) begin bad++; $display("FAIL b2b_run%0d_count got=%0d want=2", r, vec_count); end
        end
    endtask

    initial begin
        vif.vec_ready = 1'b0;
        test_reset();
        test_seed_zero();
        test_stall();
        test_zero_count();
        test_reset_mid_fill();
        test_ignored();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
